packet_serializer: RTL

- Parametrised successor to the fixed 8-bit/16-sample serializer.
- Buffers DATA_W-bit input samples in an internal FIFO.
- Once PKT_LEN samples are buffered, emits one framed packet on a valid/ready output stream: header, sequence number, PKT_LEN payload words, optional checksum, trailer.
- Sits between a sample source with no backpressure and a downstream link that can stall.

---
 rtl/packet_serializer_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 57 +++++
 rtl/packet_serializer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/packet_serializer_pkg.sv
// Shared definitions for the packet serializer: FSM state encodings,
// default framing words and a constant clog2 helper.
package packet_serializer_pkg;

  // 3-bit state encodings; the enum below is built on top of these
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_SEQ  = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
  localparam logic [2:0] ST_CHK  = 3'd4;
  localparam logic [2:0] ST_TRL  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    HDR  = ST_HDR,
    SEQ  = ST_SEQ,
    PAY  = ST_PAY,
    CHK  = ST_CHK,
    TRL  = ST_TRL
  } state_t;

  localparam logic [7:0] DEF_HDR_WORD = 8'hA5;
  localparam logic [7:0] DEF_TRL_WORD = 8'h5A;

  // Smallest r with 2**r >= value (value >= 1)
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
// The head word is visible on rd_data whenever the FIFO is not empty.
// Writes while full and reads while empty are ignored.
module sync_fifo
  import packet_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [clog2(DEPTH):0]    count,
  output logic                     full
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push;
  logic             pop;
  logic             empty;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign count   = count_reg;
  // Fall-through read: the head must be usable in the same cycle it is popped
  assign rd_data = mem[rd_ptr_reg];

  // Storage array, no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/packet_serializer.sv
// Packet serializer: buffers input samples and emits framed packets
// (header, sequence, payload, optional checksum, trailer) on a
// valid/ready stream. Define PACKET_SERIALIZER_CHECKSUM_EN to insert an
// XOR checksum word between the payload and the trailer.
//
// state_reg names the kind of word currently held in the dout register.
// A payload word is popped from the FIFO at the edge that loads it into
// dout, so the next head is directly available for the following beat.
module packet_serializer
  import packet_serializer_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                PKT_LEN    = 16,
  parameter int                FIFO_DEPTH = 32,
  parameter logic [DATA_W-1:0] HDR_WORD   = DATA_W'(DEF_HDR_WORD),
  parameter logic [DATA_W-1:0] TRL_WORD   = DATA_W'(DEF_TRL_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       pkt_cnt
);

  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              dout_valid_reg, dout_valid_next;
  logic [7:0]        idx_reg, idx_next;
  logic [7:0]        seq_reg, seq_next;
  logic [15:0]       pkt_cnt_reg, pkt_cnt_next;
  logic              overflow_reg;
  logic              pkt_ready_reg;
  logic              beat;
  logic              pop;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
  logic [DATA_W-1:0] chk_reg, chk_next;
`endif

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (din_valid),
    .wr_data (din),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  assign beat       = dout_valid_reg && dout_ready;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign busy       = (state_reg != IDLE);
  assign overflow   = overflow_reg;
  assign pkt_cnt    = pkt_cnt_reg;

  // Next state and next output word; everything holds unless a beat (or packet start) occurs
  always_comb begin
    state_next      = state_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    idx_next        = idx_reg;
    seq_next        = seq_reg;
    pkt_cnt_next    = pkt_cnt_reg;
    pop             = 1'b0;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
    chk_next        = chk_reg;
`endif
    case (state_reg)
      IDLE: begin
        dout_valid_next = 1'b0;
        if (pkt_ready_reg) begin
          state_next      = HDR;
          dout_next       = HDR_WORD;
          dout_valid_next = 1'b1;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
          chk_next        = '0;
`endif
        end
      end
      HDR: begin
        if (beat) begin
          state_next = SEQ;
          dout_next  = DATA_W'(seq_reg);
        end
      end
      SEQ: begin
        if (beat) begin
          state_next = PAY;
          dout_next  = fifo_rd_data;
          pop        = 1'b1;
          idx_next   = '0;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
          chk_next   = chk_reg ^ fifo_rd_data;
`endif
        end
      end
      PAY: begin
        if (beat) begin
          if (idx_reg == LAST_IDX) begin
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
            state_next = CHK;
            dout_next  = chk_reg;
`else
            state_next = TRL;
            dout_next  = TRL_WORD;
`endif
          end else begin
            dout_next  = fifo_rd_data;
            pop        = 1'b1;
            idx_next   = idx_reg + 8'd1;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
            chk_next   = chk_reg ^ fifo_rd_data;
`endif
          end
        end
      end
      CHK: begin
        if (beat) begin
          state_next = TRL;
          dout_next  = TRL_WORD;
        end
      end
      TRL: begin
        if (beat) begin
          state_next      = IDLE;
          dout_valid_next = 1'b0;
          pkt_cnt_next    = pkt_cnt_reg + 16'd1;
          seq_next        = seq_reg + 8'd1;
        end
      end
      default: begin
        state_next      = IDLE;
        dout_valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers; packet start waits on a registered fill flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      idx_reg        <= '0;
      seq_reg        <= '0;
      pkt_cnt_reg    <= '0;
      overflow_reg   <= 1'b0;
      pkt_ready_reg  <= 1'b0;
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
      chk_reg        <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      idx_reg        <= idx_next;
      seq_reg        <= seq_next;
      pkt_cnt_reg    <= pkt_cnt_next;
      overflow_reg   <= overflow_reg | (din_valid & fifo_full);
      pkt_ready_reg  <= (fifo_count >= CNT_W'(PKT_LEN));
`ifdef PACKET_SERIALIZER_CHECKSUM_EN
      chk_reg        <= chk_next;
`endif
    end
  end

endmodule
